// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline sequencing controller.
//   ctrl_state_t : controller FSM states
//   stage_ctrl_t : enable/clear pair for one inter-stage register
//   REG_ZERO     : architectural x0, never a real producer
package pipeline_pkg;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    RUN   = 2'd1,
    KILL  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic enable;
    logic clear;
  } stage_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   d_rs1/d_rs2, d_uses_rs1/d_uses_rs2 : sources of the instruction in ID
//   e_rd, e_is_load, e_reg_write       : destination of the instruction in EX
//   hazard_c                           : ID needs a value EX is still loading
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_uses_rs1,
  input  logic       d_uses_rs2,
  input  logic [4:0] e_rd,
  input  logic       e_is_load,
  input  logic       e_reg_write,
  output logic       hazard_c
);

  logic producer_c;
  logic match_c;

  // x0 is never written, so a load targeting it cannot create a dependency
  assign producer_c = e_is_load & e_reg_write & (e_rd != REG_ZERO);
  assign match_c    = (d_uses_rs1 & (d_rs1 == e_rd)) | (d_uses_rs2 & (d_rs2 == e_rd));
  assign hazard_c   = producer_c & match_c;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the five-stage core.
// Drives PC load enable and enable/clear of if_id, id_ex, ex_mem, mem_wb.
// Priority in RUN: dmem wait > MDU busy > EX redirect > load-use > fetch miss.
//   inputs : ID sources, EX destination/type, redirect, MDU/dmem busy, imem valid
//   outputs: f_pc_enable, {fd,de,em,mw}_{enable,clear}, f_kill, stall_count
// Stage controls are combinational from state and inputs; only the FSM state,
// the flush counter and the stall counter are registered.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         d_rs1,
  input  logic [4:0]         d_rs2,
  input  logic               d_uses_rs1,
  input  logic               d_uses_rs2,
  input  logic [4:0]         e_rd,
  input  logic               e_is_load,
  input  logic               e_reg_write,
  input  logic               e_redirect,
  input  logic               e_mdu_busy,
  input  logic               m_dmem_busy,
  input  logic               f_imem_valid,
  output logic               f_pc_enable,
  output logic               fd_enable,
  output logic               fd_clear,
  output logic               de_enable,
  output logic               de_clear,
  output logic               em_enable,
  output logic               em_clear,
  output logic               mw_enable,
  output logic               mw_clear,
  output logic               f_kill,
  output logic [STALL_W-1:0] stall_count
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  ctrl_state_t        state_q, state_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  stage_ctrl_t fd_c, de_c, em_c, mw_c;
  logic        pc_en_c;
  logic        kill_c;
  logic        load_use_c;
  logic        frozen_c;

  load_use_detect u_load_use (
    .d_rs1       (d_rs1),
    .d_rs2       (d_rs2),
    .d_uses_rs1  (d_uses_rs1),
    .d_uses_rs2  (d_uses_rs2),
    .e_rd        (e_rd),
    .e_is_load   (e_is_load),
    .e_reg_write (e_reg_write),
    .hazard_c    (load_use_c)
  );

  // EX is held while memory or the MDU is busy; a pending redirect waits it out
  assign frozen_c = m_dmem_busy | e_mdu_busy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= CNT_W'(FLUSH_CYCLES - 1);
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_q     <= stall_d;
    end
  end

  // Next-state, flush counter and stall counter
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall_d     = stall_q;
    unique case (state_q)
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = RUN;
        else                   flush_cnt_d = flush_cnt_q - CNT_W'(1);
      end
      RUN: begin
        if (!frozen_c && e_redirect && !f_imem_valid) state_d = KILL;
        if (!pc_en_c && (stall_q != '1)) stall_d = stall_q + STALL_W'(1);
      end
      KILL: begin
        // The arriving wrong-path word is dropped by fd_clear this cycle
        if (!frozen_c && f_imem_valid) state_d = RUN;
      end
      default: state_d = FLUSH;
    endcase
  end

  // Output decode
  always_comb begin
    pc_en_c = 1'b0;
    kill_c  = 1'b0;
    fd_c    = '{enable: 1'b1, clear: 1'b0};
    de_c    = '{enable: 1'b1, clear: 1'b0};
    em_c    = '{enable: 1'b1, clear: 1'b0};
    mw_c    = '{enable: 1'b1, clear: 1'b0};
    unique case (state_q)
      RUN, KILL: begin
        kill_c = (state_q == KILL);
        if (m_dmem_busy) begin
          // Full freeze, bubble into WB
          fd_c.enable = 1'b0;
          de_c.enable = 1'b0;
          em_c.enable = 1'b0;
          mw_c.enable = 1'b0;
          mw_c.clear  = 1'b1;
        end else if (e_mdu_busy) begin
          // Hold front end and EX, let MEM drain into WB
          fd_c.enable = 1'b0;
          de_c.enable = 1'b0;
          em_c.clear  = 1'b1;
        end else if (state_q == KILL) begin
          fd_c.clear = 1'b1;
        end else if (e_redirect) begin
          pc_en_c    = 1'b1;
          fd_c.clear = 1'b1;
          de_c.clear = 1'b1;
        end else if (load_use_c) begin
          fd_c.enable = 1'b0;
          de_c.clear  = 1'b1;
        end else if (!f_imem_valid) begin
          fd_c.clear = 1'b1;
        end else begin
          pc_en_c = 1'b1;
        end
      end
      default: begin
        // FLUSH: every stage register held cleared, PC frozen
        fd_c.clear = 1'b1;
        de_c.clear = 1'b1;
        em_c.clear = 1'b1;
        mw_c.clear = 1'b1;
      end
    endcase
  end

  assign f_pc_enable = pc_en_c;
  assign fd_enable   = fd_c.enable;
  assign fd_clear    = fd_c.clear;
  assign de_enable   = de_c.enable;
  assign de_clear    = de_c.clear;
  assign em_enable   = em_c.enable;
  assign em_clear    = em_c.clear;
  assign mw_enable   = mw_c.enable;
  assign mw_clear    = mw_c.clear;
  assign f_kill      = kill_c;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller. A second instance with a 2-bit stall
// counter shares the stimulus so saturation is reached within a short run.
module tb_hazard_controller;

  // Control vector: {pc_en, fd_en, fd_clr, de_en, de_clr, em_en, em_clr, mw_en, mw_clr, kill}
  localparam logic [9:0] V_FLUSH = 10'b0_11_11_11_11_0;
  localparam logic [9:0] V_RUN   = 10'b1_10_10_10_10_0;
  localparam logic [9:0] V_LU    = 10'b0_00_11_10_10_0;
  localparam logic [9:0] V_DMEM  = 10'b0_00_00_00_01_0;
  localparam logic [9:0] V_MDU   = 10'b0_00_00_11_10_0;
  localparam logic [9:0] V_REDIR = 10'b1_11_11_10_10_0;
  localparam logic [9:0] V_MISS  = 10'b0_11_10_10_10_0;
  localparam logic [9:0] V_KILL  = 10'b0_11_10_10_10_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] d_rs1, d_rs2, e_rd;
  logic       d_uses_rs1, d_uses_rs2, e_is_load, e_reg_write;
  logic       e_redirect, e_mdu_busy, m_dmem_busy, f_imem_valid;

  logic        a_pc, a_fde, a_fdc, a_dee, a_dec, a_eme, a_emc, a_mwe, a_mwc, a_kill;
  logic        b_pc, b_fde, b_fdc, b_dee, b_dec, b_eme, b_emc, b_mwe, b_mwc, b_kill;
  logic [31:0] cnt_a;
  logic [1:0]  cnt_b;
  logic [9:0]  vec_a, vec_b;

  assign vec_a = {a_pc, a_fde, a_fdc, a_dee, a_dec, a_eme, a_emc, a_mwe, a_mwc, a_kill};
  assign vec_b = {b_pc, b_fde, b_fdc, b_dee, b_dec, b_eme, b_emc, b_mwe, b_mwc, b_kill};

  hazard_controller #(.FLUSH_CYCLES(2), .STALL_W(32)) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_rd(e_rd), .e_is_load(e_is_load), .e_reg_write(e_reg_write),
    .e_redirect(e_redirect), .e_mdu_busy(e_mdu_busy), .m_dmem_busy(m_dmem_busy),
    .f_imem_valid(f_imem_valid),
    .f_pc_enable(a_pc), .fd_enable(a_fde), .fd_clear(a_fdc),
    .de_enable(a_dee), .de_clear(a_dec), .em_enable(a_eme), .em_clear(a_emc),
    .mw_enable(a_mwe), .mw_clear(a_mwc), .f_kill(a_kill), .stall_count(cnt_a)
  );

  hazard_controller #(.FLUSH_CYCLES(2), .STALL_W(2)) dut_w2 (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_rd(e_rd), .e_is_load(e_is_load), .e_reg_write(e_reg_write),
    .e_redirect(e_redirect), .e_mdu_busy(e_mdu_busy), .m_dmem_busy(m_dmem_busy),
    .f_imem_valid(f_imem_valid),
    .f_pc_enable(b_pc), .fd_enable(b_fde), .fd_clear(b_fdc),
    .de_enable(b_dee), .de_clear(b_dec), .em_enable(b_eme), .em_clear(b_emc),
    .mw_enable(b_mwe), .mw_clear(b_mwc), .f_kill(b_kill), .stall_count(cnt_b)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the current cycle, advance one clock, update the expected stall count
  task automatic cyc(input string tag, input logic [9:0] ev, input bit stall);
    #1;
    chk({tag, "/ctl"}, 32'(vec_a), 32'(ev));
    chk({tag, "/ctl_w2"}, 32'(vec_b), 32'(ev));
    chk({tag, "/cnt"}, cnt_a, exp_cnt);
    chk({tag, "/cnt_w2"}, 32'(cnt_b), (exp_cnt > 32'd3) ? 32'd3 : exp_cnt);
    @(posedge clk);
    if (stall) exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    d_rs1 = 5'd0; d_rs2 = 5'd0; e_rd = 5'd0;
    d_uses_rs1 = 1'b0; d_uses_rs2 = 1'b0; e_is_load = 1'b0; e_reg_write = 1'b0;
    e_redirect = 1'b0; e_mdu_busy = 1'b0; m_dmem_busy = 1'b0; f_imem_valid = 1'b1;
    exp_cnt = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset and flush window
    cyc("reset_hold", V_FLUSH, 1'b0);
    reset = 1'b0;
    cyc("flush1", V_FLUSH, 1'b0);
    cyc("flush2", V_FLUSH, 1'b0);
    cyc("run", V_RUN, 1'b0);

    // Load-use on rs2, then the load moves on
    e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5; d_uses_rs2 = 1'b1; d_rs2 = 5'd5;
    cyc("lu_rs2", V_LU, 1'b1);
    e_is_load = 1'b0;
    cyc("lu_after", V_RUN, 1'b0);

    // Load to x0 never stalls
    e_is_load = 1'b1; e_rd = 5'd0; d_rs2 = 5'd0;
    cyc("lu_x0", V_RUN, 1'b0);

    // rs1 matches but is not read, then is read
    e_rd = 5'd7; d_rs2 = 5'd3; d_rs1 = 5'd7; d_uses_rs1 = 1'b0;
    cyc("lu_unused", V_RUN, 1'b0);
    d_uses_rs1 = 1'b1;
    cyc("lu_rs1", V_LU, 1'b1);
    e_reg_write = 1'b0;
    cyc("lu_nowrite", V_RUN, 1'b0);
    e_is_load = 1'b0; d_uses_rs1 = 1'b0; d_uses_rs2 = 1'b0;

    // Fetch miss and MDU busy
    f_imem_valid = 1'b0;
    cyc("imiss", V_MISS, 1'b1);
    f_imem_valid = 1'b1; e_mdu_busy = 1'b1;
    cyc("mdu", V_MDU, 1'b1);
    e_mdu_busy = 1'b0;

    // Redirect with fetch pending, wrong-path response 3 cycles later
    e_redirect = 1'b1; f_imem_valid = 1'b0;
    cyc("redir_miss", V_REDIR, 1'b0);
    e_redirect = 1'b0;
    cyc("kill1", V_KILL, 1'b0);
    cyc("kill2", V_KILL, 1'b0);
    f_imem_valid = 1'b1;
    cyc("kill3", V_KILL, 1'b0);
    cyc("kill_exit", V_RUN, 1'b0);

    // Dmem wait with redirect held: freeze then redirect acted on
    m_dmem_busy = 1'b1; e_redirect = 1'b1;
    for (int i = 0; i < 4; i++) cyc("freeze", V_DMEM, 1'b1);
    m_dmem_busy = 1'b0;
    cyc("unfreeze_redir", V_REDIR, 1'b0);
    e_redirect = 1'b0;
    cyc("post_redir", V_RUN, 1'b0);

    // Reset while in KILL
    e_redirect = 1'b1; f_imem_valid = 1'b0;
    cyc("redir2", V_REDIR, 1'b0);
    e_redirect = 1'b0;
    cyc("kill_pre", V_KILL, 1'b0);
    reset = 1'b1;
    cyc("kill_rst", V_KILL, 1'b0);
    exp_cnt = 32'd0;
    reset = 1'b0; f_imem_valid = 1'b1;
    cyc("rst_flush1", V_FLUSH, 1'b0);
    cyc("rst_flush2", V_FLUSH, 1'b0);
    cyc("rst_run", V_RUN, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
